// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM/mode encodings and op classification for alu_seq.
// The divider opcodes count as iterative only when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_e;

    typedef enum logic [1:0] {MD_MUL, MD_DIVU, MD_REMU} md_mode_e;

    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL);
`endif
    endfunction

    function automatic md_mode_e md_mode(input logic [3:0] op);
        case (op)
            OP_DIVU: return MD_DIVU;
            OP_REMU: return MD_REMU;
            default: return MD_MUL;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath: shift-add multiplier and, with ALU_SEQ_DIV_EN, a restoring divider.
// One step per cycle for WIDTH cycles after start; res is the post-step value, valid with done.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int CW = $clog2(WIDTH) + 1;

    // acc: product accumulator / remainder; x: shifting multiplicand / divisor;
    // y: multiplier being consumed / dividend shifting out while quotient shifts in.
    logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   rem_sh, rem_sub;
`endif

    always_comb begin
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
`ifdef ALU_SEQ_DIV_EN
        rem_sh  = {acc_q, y_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, x_q};
`endif
        if (start) begin
            acc_d  = '0;
            x_d    = a;
            y_d    = b;
            cnt_d  = CW'(WIDTH);
            mode_d = mode;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (mode_q == MD_MUL) begin
                if (y_q[0]) acc_d = acc_q + x_q;
                x_d = x_q << 1;
                y_d = y_q >> 1;
`ifdef ALU_SEQ_DIV_EN
            end else if (rem_sh >= {1'b0, x_q}) begin
                acc_d = rem_sub[WIDTH-1:0];
                y_d   = {y_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = rem_sh[WIDTH-1:0];
                y_d   = {y_q[WIDTH-2:0], 1'b0};
`endif
            end
        end
    end

    assign done = (cnt_q == CW'(1));

`ifdef ALU_SEQ_DIV_EN
    assign res = (mode_q == MD_DIVU) ? y_d : acc_d;
`else
    assign res = (mode_q == MD_MUL) ? acc_d : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            cnt_q  <= '0;
            mode_q <= MD_MUL;
        end else begin
            acc_q  <= acc_d;
            x_q    <= x_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU: single-cycle ops via EXEC, MUL (and DIVU/REMU when
// ALU_SEQ_DIV_EN is defined) via the iterative alu_seq_muldiv datapath.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
    localparam int M = WIDTH - 1;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, carry_q, carry_d;
    logic             ovf_q, ovf_d, ill_q, ill_d;

    logic             accept, md_start, md_done;
    logic [WIDTH-1:0] md_res;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v, alu_ill;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   sh;

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && is_iter_op(op);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .mode  (md_mode(op)),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .res   (md_res)
    );

    // Single-cycle ALU over the latched operands.
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        sh      = b_q[SHW-1:0];
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_r = sum[M:0];
                alu_c = sum[WIDTH];
                alu_v = (a_q[M] == b_q[M]) && (alu_r[M] != a_q[M]);
            end
            OP_SUB: begin
                alu_r = diff[M:0];
                alu_c = diff[WIDTH];
                alu_v = (a_q[M] != b_q[M]) && (alu_r[M] != a_q[M]);
            end
            OP_AND:  alu_r = a_q & b_q;
            OP_OR:   alu_r = a_q | b_q;
            OP_NOT:  alu_r = ~a_q;
            OP_XOR:  alu_r = a_q ^ b_q;
            OP_SLT:  alu_r[0] = $signed(a_q) < $signed(b_q);
            OP_SLTU: begin
                alu_r[0] = diff[WIDTH];
                alu_c    = diff[WIDTH];
            end
            OP_SLL:  alu_r = a_q << sh;
            OP_SRL:  alu_r = a_q >> sh;
            OP_SRA:  alu_r = $unsigned($signed(a_q) >>> sh);
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d    = op;
                a_d     = a;
                b_d     = b;
                state_d = is_iter_op(op) ? ITER : EXEC;
            end
            EXEC: begin
                result_d = alu_r;
                zero_d   = (alu_r == '0);
                carry_d  = alu_c;
                ovf_d    = alu_v;
                ill_d    = alu_ill;
                state_d  = DONE;
            end
            ITER: if (md_done) begin
                result_d = md_res;
                zero_d   = (md_res == '0);
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
                ill_d    = 1'b0;
                state_d  = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32); divider checks follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero, carry, overflow, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // flags = {zero, carry, overflow, illegal}; lat counts cycles from the accept
    // cycle to the first out_valid cycle. hold keeps out_ready low that many cycles.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic [W-1:0] exp_r,
                          input logic [3:0] exp_f, input int exp_lat, input int hold);
        int lat;
        out_ready = (hold == 0);
        op = o; a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = '0; a = '0; b = '0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".res"}, result, exp_r);
        chk({tag, ".flags"}, {zero, carry, overflow, illegal}, exp_f);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_res"}, result, exp_r);
            chk({tag, ".hold_hs"}, {out_valid, in_ready}, 2'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".post"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #1;
        chk("rst.hs", {out_valid, in_ready}, 2'b00);
        chk("rst.res", result, 32'h0);
        chk("rst.flags", {zero, carry, overflow, illegal}, 4'b0000);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle.hs", {out_valid, in_ready}, 2'b01);

        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1100, 2, 0);
        run_op("sub_ovf", 4'b0001, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0010, 2, 0);
        run_op("add_povf", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0010, 2, 0);
        run_op("sub_borrow", 4'b0001, 32'h3, 32'h5, 32'hFFFF_FFFE, 4'b0100, 2, 0);
        run_op("slt", 4'b0101, 32'hFFFF_FFFF, 32'h0, 32'h1, 4'b0000, 2, 0);
        run_op("sltu", 4'b0110, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'b1000, 2, 0);
        run_op("and", 4'b0010, 32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034, 4'b0000, 2, 0);
        run_op("xor", 4'b0111, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 4'b0000, 2, 0);
        run_op("not", 4'b0100, 32'h0F0F_0000, 32'h1234, 32'hF0F0_FFFF, 4'b0000, 2, 0);
        run_op("sra", 4'b1010, 32'hF000_0000, 32'h4, 32'hFF00_0000, 4'b0000, 2, 0);
        run_op("srl", 4'b1001, 32'hF000_0000, 32'h4, 32'h0F00_0000, 4'b0000, 2, 0);
        run_op("sll0", 4'b1000, 32'h1234_5678, 32'h0, 32'h1234_5678, 4'b0000, 2, 0);
        run_op("sll20", 4'b1000, 32'h1234_5678, 32'h20, 32'h1234_5678, 4'b0000, 2, 0);
        run_op("illegal", 4'b1111, 32'h1, 32'h2, 32'h0, 4'b1001, 2, 0);
        run_op("mul", 4'b1011, 32'd12345, 32'd678, 32'd8369910, 4'b0000, 33, 5);
        run_op("mul_wrap", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 4'b0000, 33, 0);
`ifdef ALU_SEQ_DIV_EN
        run_op("divu", 4'b1100, 32'd100, 32'd7, 32'd14, 4'b0000, 33, 0);
        run_op("remu", 4'b1101, 32'd100, 32'd7, 32'd2, 4'b0000, 33, 0);
        run_op("divu0", 4'b1100, 32'd55, 32'd0, 32'hFFFF_FFFF, 4'b0000, 33, 0);
        run_op("remu0", 4'b1101, 32'd55, 32'd0, 32'd55, 4'b0000, 33, 0);
`else
        run_op("divu_ill", 4'b1100, 32'd100, 32'd7, 32'h0, 4'b1001, 2, 0);
        run_op("remu_ill", 4'b1101, 32'd100, 32'd7, 32'h0, 4'b1001, 2, 0);
`endif

        // Reset in the middle of a multiply: the operation must vanish.
        op = 4'b1011; a = 32'd1000; b = 32'd1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrst.busy", {out_valid, in_ready}, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("midrst.in_rst", {out_valid, in_ready}, 2'b00);
        chk("midrst.res", result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst.after", {out_valid, in_ready}, 2'b01);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("midrst.no_out", seen, 0);
        end
        run_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
